// File: rtl/jtcop_objdma.sv
// Object-table DMA: copies 2^AW words of object RAM into the hidden bank of a
// double-buffered sprite table, yielding the shared read port to the CPU.
module jtcop_objdma #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          obj_copy,
    input  logic          cpu_cs,
    output logic [AW-1:0] src_addr,
    output logic          src_rd,
    input  logic [15:0]   src_data,
    output logic [AW:0]   dst_addr,
    output logic [15:0]   dst_data,
    output logic          dst_we,
    output logic          disp_bank,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [AW:0]   rd_cnt;
    logic          pending;
    logic          rd_v1;
    logic [AW-1:0] rd_addr1;
    logic          last_rd, last_wr, restart;

    assign last_rd = src_rd && (rd_cnt[AW-1:0] == {AW{1'b1}});
    // The final write is the one with nothing left behind it in the data stage.
    assign last_wr = (state == DRAIN) && dst_we && !rd_v1;
    // A request landing on the completion edge folds into the restart decision.
    assign restart = pending || obj_copy;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (obj_copy) state_nx = COPY;
            COPY:    if (last_rd)  state_nx = DRAIN;
            DRAIN:   if (last_wr)  state_nx = restart ? COPY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        src_rd   = (state == COPY) && !cpu_cs && !rd_cnt[AW];
        src_addr = rd_cnt[AW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            pending   <= 1'b0;
            done      <= 1'b0;
            disp_bank <= 1'b0;
            rd_v1     <= 1'b0;
            rd_addr1  <= '0;
            dst_we    <= 1'b0;
            dst_data  <= '0;
            dst_addr  <= '0;
        end else begin
            if (state_nx == COPY && state != COPY)
                rd_cnt <= '0;
            else if (src_rd)
                rd_cnt <= rd_cnt + {{AW{1'b0}}, 1'b1};

            if (last_wr)
                pending <= 1'b0;
            else if (busy && obj_copy)
                pending <= 1'b1;

            done <= last_wr;
            if (last_wr)
                disp_bank <= ~disp_bank;

            // Read issued in t, data captured at end of t+1, written in t+2.
            rd_v1 <= src_rd;
            if (src_rd)
                rd_addr1 <= src_addr;
            dst_we <= rd_v1;
            if (rd_v1) begin
                dst_data <= src_data;
                dst_addr <= {~disp_bank, rd_addr1};
            end
        end
    end

endmodule

// File: tb/tb_jtcop_objdma.sv
// Bench for jtcop_objdma: the driver queues the writes each copy must produce,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_jtcop_objdma;

    localparam int AW = 4;
    localparam int N  = 1 << AW;

    typedef logic [AW+16:0] wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          obj_copy = 1'b0;
    logic          cpu_cs = 1'b0;
    logic [AW-1:0] src_addr;
    logic          src_rd;
    logic [15:0]   src_data = '0;
    logic [AW:0]   dst_addr;
    logic [15:0]   dst_data;
    logic          dst_we, disp_bank, busy, done;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic [15:0] ram [N];
    wr_t  exp_q [$];
    logic model_bank = 1'b0;

    jtcop_objdma #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .obj_copy  (obj_copy),
        .cpu_cs    (cpu_cs),
        .src_addr  (src_addr),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .dst_we    (dst_we),
        .disp_bank (disp_bank),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (src_rd) src_data <= ram[src_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every buffer write must match the head of the expected queue.
    always @(negedge clk) begin
        if (src_rd) check("rd_while_cpu", 32'(cpu_cs), 32'd0);
        if (dst_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h, none expected", dst_addr, dst_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write", 32'({dst_addr, dst_data}), 32'(e));
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ram(input logic rnd);
        for (int i = 0; i < N; i++)
            ram[i] = rnd ? 16'($urandom) : 16'hA000 + 16'(i);
    endtask

    // Reference: a copy writes every word in address order into the bank not displayed.
    task automatic push_copy();
        logic [AW-1:0] a;
        model_bank = ~model_bank;
        for (int i = 0; i < N; i++) begin
            a = i[AW-1:0];
            exp_q.push_back({model_bank, a, ram[i]});
        end
    endtask

    task automatic trigger(output int t0);
        obj_copy = 1'b1;
        tick();
        obj_copy = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget, input logic chk_busy, output int td);
        td = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                td = cyc;
                break;
            end
            if (chk_busy) check("busy_held", 32'(busy), 32'd1);
        end
        if (td < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic finish_copy(input int t0, input int exp_lat, input string tag);
        int td;
        wait_done(400, 1'b1, td);
        if (td >= 0) check({tag, "_latency"}, 32'(td - t0 + 1), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_bank"}, 32'(disp_bank), 32'(model_bank));
        check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic pulse_at(input int c);
        while (cyc < c) begin
            tick();
            check("busy_between", 32'(busy), 32'd1);
        end
        obj_copy = 1'b1;
        tick();
        obj_copy = 1'b0;
        check("busy_between", 32'(busy), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_dst_we"}, 32'(dst_we), 32'd0);
        check({tag, "_src_rd"}, 32'(src_rd), 32'd0);
        check({tag, "_disp_bank"}, 32'(disp_bank), 32'd0);
        check({tag, "_dst_addr"}, 32'(dst_addr), 32'd0);
        check({tag, "_dst_data"}, 32'(dst_data), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, t1, td, n, used, base;
        logic first_bank;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Single copy of a known pattern into bank 1.
        load_ram(1'b0);
        push_copy();
        trigger(t0);
        check("busy_start", 32'(busy), 32'd1);
        finish_copy(t0, N + 3, "copy1");

        // Second copy lands in bank 0.
        load_ram(1'b1);
        push_copy();
        trigger(t0);
        finish_copy(t0, N + 3, "copy2");

        // Five-cycle CPU stall mid-copy.
        load_ram(1'b1);
        push_copy();
        trigger(t0);
        repeat (4) tick();
        cpu_cs = 1'b1;
        repeat (5) tick();
        cpu_cs = 1'b0;
        finish_copy(t0, N + 3 + 5, "stall5");

        // Random stall patterns: done follows the last issued read by three cycles.
        for (int k = 0; k < 4; k++) begin
            load_ram(1'b1);
            push_copy();
            trigger(t0);
            n = 0;
            used = 0;
            while (n < N) begin
                cpu_cs = ($urandom_range(0, 2) == 0);
                if (!cpu_cs) n++;
                used++;
                tick();
            end
            cpu_cs = 1'b0;
            finish_copy(t0, used + 3, "rand");
        end

        // Retrigger: three requests while busy plus one on the completion edge.
        load_ram(1'b1);
        push_copy();
        first_bank = model_bank;
        push_copy();
        base = done_cnt;
        trigger(t0);
        pulse_at(t0 + 2);
        pulse_at(t0 + 5 + int'($urandom_range(0, 3)));
        pulse_at(t0 + 11 + int'($urandom_range(0, 3)));
        while (cyc < t0 + N + 1) begin
            tick();
            check("busy_between", 32'(busy), 32'd1);
        end
        obj_copy = 1'b1;
        tick();
        obj_copy = 1'b0;
        check("retrig_first_done", 32'(done), 32'd1);
        check("retrig_first_latency", 32'(cyc - t0 + 1), 32'(N + 3));
        check("retrig_busy_kept", 32'(busy), 32'd1);
        check("retrig_first_bank", 32'(disp_bank), 32'(first_bank));
        t1 = cyc;
        wait_done(400, 1'b1, td);
        if (td >= 0) check("retrig_second_latency", 32'(td - t1 + 1), 32'(N + 3));
        check("retrig_second_busy", 32'(busy), 32'd0);
        check("retrig_second_bank", 32'(disp_bank), 32'(model_bank));
        check("retrig_all_written", 32'(exp_q.size()), 32'd0);
        repeat (40) tick();
        check("retrig_done_count", 32'(done_cnt - base), 32'd2);
        check("retrig_idle", 32'(busy), 32'd0);

        // Reset while the seventh read is on the port.
        load_ram(1'b1);
        push_copy();
        trigger(t0);
        repeat (6) tick();
        check("abort_src_rd", 32'(src_rd), 32'd1);
        check("abort_src_addr", 32'(src_addr), 32'd6);
        base = done_cnt;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_bank = 1'b0;
        check_reset_outputs("abort");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        load_ram(1'b1);
        push_copy();
        trigger(t0);
        finish_copy(t0, N + 3, "after_abort");

        // CPU holds the port for 100 cycles from the trigger.
        load_ram(1'b1);
        push_copy();
        cpu_cs = 1'b1;
        trigger(t0);
        for (int i = 0; i < 100; i++) begin
            check("hold_no_read", 32'(src_rd), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            tick();
        end
        check("hold_no_write", 32'(exp_q.size()), 32'(N));
        cpu_cs = 1'b0;
        finish_copy(t0, N + 3 + 100, "hold100");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtcop_objdma.md
# jtcop_objdma

Object-table DMA engine for the Dec0-era boards. It starts a full copy of the CPU-visible object RAM into a double-banked sprite line buffer when the address decoder pulses `obj_copy` (once per frame, at LVBL falling edge). It sits directly downstream of the decoder's `obj_copy`/`obj_cs` outputs and upstream of the object renderer, which reads the bank selected by `disp_bank`. CPU accesses to object RAM always win the shared read port; the DMA stalls around them.

## Interface
- `AW`, 10: word-address width of object RAM; copy length is 2^AW words.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `obj_copy`  in  1  copy request pulse from decoder (obj_copy / *DM).
- `cpu_cs`  in  1  CPU owns object RAM read port this cycle (decoder `obj_cs`).
- `src_addr`  out  AW  object RAM read address.
- `src_rd`  out  1  read strobe; RAM returns `src_data` in the following cycle.
- `src_data`  in  16  object RAM read data.
- `dst_addr`  out  AW+1  buffer write address, MSB = bank.
- `dst_data`  out  16  buffer write data.
- `dst_we`  out  1  buffer write enable.
- `disp_bank`  out  1  bank the renderer reads.
- `busy`  out  1  copy in progress.
- `done`  out  1  one-cycle pulse at copy completion.

## Operation
- States: IDLE, COPY, DRAIN.
- IDLE: on `obj_copy`=1 at an edge, go to COPY, clear read counter `rd_cnt` (AW+1 bits), `busy`=1.
- COPY: `src_rd` = !`cpu_cs`, combinational from registered state; `src_addr` = `rd_cnt[AW-1:0]`. Each cycle with `src_rd`=1, `rd_cnt`++. When the read of address 2^AW-1 issues, go to DRAIN.
- `cpu_cs`=1: no read issued, `rd_cnt` held; in-flight data still written. No limit on stall length.
- Write pipe: read issued cycle t; `src_data` registered at end of t+1; `dst_we`=1, `dst_data`, `dst_addr`={~`disp_bank`, addr} valid in cycle t+2. `dst_we` high only for issued reads, in issue order, no gaps other than stall gaps.
- DRAIN: wait until last write has completed, then: toggle `disp_bank`, pulse `done`, return to IDLE (`busy`=0) or restart (below).
- Retrigger: `obj_copy` while `busy` (including the `done` cycle) sets `pending`; multiple requests collapse to one. At completion with `pending`: `done` still pulses, `disp_bank` toggles, `pending` clears, state goes straight to COPY, `busy` stays 1.
- Writes always target the non-displayed bank; renderer never sees a partial table.

## Timing
- Reset (`rst_n`=0, async): state IDLE, `busy`=0, `done`=0, `dst_we`=0, `src_rd`=0, `disp_bank`=0, `pending`=0, `rd_cnt`=0, `dst_addr`=0, `dst_data`=0. Reset mid-copy aborts immediately; `disp_bank` returns to 0, no `done`.
- Trigger sampled at edge E: `busy` high from cycle E+1; reads in E+1..E+2^AW with no stalls; writes in E+3..E+2^AW+2; `done`=1 and `disp_bank` toggled in cycle E+2^AW+3; `busy`=0 in that cycle (unless restarting).
- Each stalled cycle adds exactly one cycle to all later events.
- Copy of 2^AW words, no stalls: 2^AW+3 cycles trigger-to-done.
- `src_rd` never high while `cpu_cs`=1.

## Test plan
- Reset, AW=4, RAM[i]=16'hA000+i, single `obj_copy` -> 16 writes to dst_addr 16..31 with data A000..A00F, `done` 19 cycles after trigger edge, `disp_bank` 0->1.
- Second copy after first -> writes to dst_addr 0..15, `disp_bank` 1->0, bank 1 contents untouched.
- `cpu_cs` held high 5 cycles mid-copy -> `src_rd` low those cycles, no address skipped or repeated, `done` delayed by exactly 5 cycles.
- Three `obj_copy` pulses during busy, one more in `done` cycle -> exactly one extra copy, `busy` never drops between copies, two `done` pulses total.
- `rst_n` low at read 7 of a copy -> all outputs at reset values same cycle, `disp_bank`=0, no `done`; fresh trigger afterwards completes normally.
- `cpu_cs`=1 continuously for 100 cycles from trigger -> no reads, no writes, `busy` stays 1; release -> copy completes with correct data.
